// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between a mode-3 SPI master and the register-file slave.
interface spi_slave_regfile_if;
  logic spi_clk_i;
  logic spi_mosi_i;
  logic spi_cs_i;
  logic spi_miso_o;

  modport master (output spi_clk_i, spi_mosi_i, spi_cs_i, input spi_miso_o);
  modport slave  (input spi_clk_i, spi_mosi_i, spi_cs_i, output spi_miso_o);
endinterface

// File: rtl/spi_slave_regfile.sv
// Oversampled mode-3 SPI slave in front of a byte-wide register file.
// Frame: command byte {rw, addr[6:0]} followed by auto-incrementing data bytes.
module spi_slave_regfile #(
  parameter int         REG_COUNT = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  spi_slave_regfile_if.slave     spi,
  output logic [REG_COUNT*8-1:0] reg_o,
  output logic                   wr_valid_o,
  output logic [6:0]             wr_addr_o,
  output logic [7:0]             wr_data_o,
  output logic                   addr_err_o,
  output logic                   frame_done_o
);

  typedef enum logic [1:0] {IDLE, CMD, DATA_WR, DATA_RD} state_e;

  localparam logic [7:0] RC_W = 8'(REG_COUNT);

  state_e                        state_q, state_d;
  logic [2:0]                    clk_sync_q, cs_sync_q;
  logic [1:0]                    mosi_sync_q;
  logic [2:0]                    bit_cnt_q, bit_cnt_d;
  logic [7:0]                    rx_q, rx_d;
  logic [7:0]                    tx_q, tx_d;
  logic [6:0]                    addr_q, addr_d;
  logic                          miso_q, miso_d;
  logic                          got_byte_q, got_byte_d;
  logic [REG_COUNT-1:0][7:0]     regs_q, regs_d;
  logic                          wr_valid_q, wr_valid_d;
  logic [6:0]                    wr_addr_q, wr_addr_d;
  logic [7:0]                    wr_data_q, wr_data_d;
  logic                          addr_err_q, addr_err_d;
  logic                          frame_done_q, frame_done_d;

  logic       sck_rise, sck_fall, cs_hi, cs_fall;
  logic [7:0] rx_byte;
  logic [6:0] ld_addr;
  logic [7:0] ld_byte;
  logic       ld_ok, wr_ok;

  assign sck_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign sck_fall = ~clk_sync_q[1] & clk_sync_q[2];
  assign cs_hi    = cs_sync_q[1];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign rx_byte  = {rx_q[6:0], mosi_sync_q[1]};

  // The command byte supplies the first read address before addr_q holds it.
  assign ld_addr = (state_q == CMD) ? rx_byte[6:0] : addr_q;
  assign ld_ok   = {1'b0, ld_addr} < RC_W;
  assign wr_ok   = {1'b0, addr_q} < RC_W;

  always_comb begin
    ld_byte = '0;
    for (int i = 0; i < REG_COUNT; i++)
      if (ld_addr == 7'(i)) ld_byte = regs_q[i];
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    miso_d       = miso_q;
    got_byte_d   = got_byte_q;
    regs_d       = regs_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    addr_err_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = CMD;
          bit_cnt_d  = '0;
          rx_d       = '0;
          got_byte_d = 1'b0;
        end
      end
      default: begin
        if (cs_hi) begin
          // Partial bytes are simply dropped with the frame.
          state_d      = IDLE;
          miso_d       = 1'b0;
          bit_cnt_d    = '0;
          frame_done_d = got_byte_q;
        end else begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = rx_byte;
            if (bit_cnt_q == 3'd7) begin
              got_byte_d = 1'b1;
              if (state_q == DATA_WR) begin
                if (wr_ok) begin
                  for (int i = 0; i < REG_COUNT; i++)
                    if (addr_q == 7'(i)) regs_d[i] = rx_byte;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = addr_q;
                  wr_data_d  = rx_byte;
                end else begin
                  addr_err_d = 1'b1;
                end
                addr_d = addr_q + 7'd1;
              end else if (state_q == CMD && !rx_byte[7]) begin
                state_d = DATA_WR;
                addr_d  = rx_byte[6:0];
              end else begin
                state_d    = DATA_RD;
                tx_d       = ld_ok ? ld_byte : 8'h00;
                addr_err_d = ~ld_ok;
                addr_d     = ld_addr + 7'd1;
              end
            end
          end
          if (sck_fall && state_q == DATA_RD) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      clk_sync_q   <= 3'b111;
      // CS history starts low so a CS held low through reset never looks like
      // a falling edge; a new frame needs CS to go high first.
      cs_sync_q    <= 3'b000;
      mosi_sync_q  <= 2'b00;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      miso_q       <= 1'b0;
      got_byte_q   <= 1'b0;
      regs_q       <= {REG_COUNT{RESET_VAL}};
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      addr_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], spi.spi_clk_i};
      cs_sync_q    <= {cs_sync_q[1:0], spi.spi_cs_i};
      mosi_sync_q  <= {mosi_sync_q[0], spi.spi_mosi_i};
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      miso_q       <= miso_d;
      got_byte_q   <= got_byte_d;
      regs_q       <= regs_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      addr_err_q   <= addr_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign spi.spi_miso_o = miso_q;
  assign reg_o          = regs_q;
  assign wr_valid_o     = wr_valid_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign addr_err_o     = addr_err_q;
  assign frame_done_o   = frame_done_q;

endmodule
